// File: rtl/shift_add_mac_if.sv
// rtl/shift_add_mac_if.sv - operand/result handshake bundle for the shift-add MAC
interface shift_add_mac_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               ACC;
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] P;
    logic               OVF;

    // Producer of operands and consumer of results
    modport master (
        output A, B, ACC, in_valid, out_ready,
        input  in_ready, out_valid, P, OVF
    );

    // The MAC itself
    modport slave (
        input  A, B, ACC, in_valid, out_ready,
        output in_ready, out_valid, P, OVF
    );
endinterface

// File: rtl/shift_add_mac.sv
// rtl/shift_add_mac.sv - sequential shift-and-add multiplier / accumulator, one multiplier bit per cycle
module shift_add_mac #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    shift_add_mac_if.slave bus
);
    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    mcand_q, mcand_d;     // multiplicand, pre-shifted to the current bit weight
    logic [WIDTH-1:0] mplier_q, mplier_d;   // multiplier, consumed from bit 0
    logic [DW-1:0]    work_q, work_d;       // running accumulation
    logic             carry_q, carry_d;     // sticky carry out of bit DW-1
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    p_q, p_d;
    logic             ovf_q, ovf_d;
    logic [DW:0]      sum;

    // The sum P_prev + A*B stays below 2^(DW+1), so at most one partial add
    // can carry out; a sticky OR of per-step carries is the final carry.

    // Next-state, datapath and handshake outputs
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        work_d   = work_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        ovf_d    = ovf_q;
        sum      = {1'b0, work_q} + {1'b0, (mplier_q[0] ? mcand_q : {DW{1'b0}})};

        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.A};
                    mplier_d = bus.B;
                    work_d   = bus.ACC ? p_q : {DW{1'b0}};
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                work_d   = sum[DW-1:0];
                carry_d  = carry_q | sum[DW];
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    p_d     = sum[DW-1:0];
                    ovf_d   = carry_q | sum[DW];
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            work_q   <= work_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.P   = p_q;
    assign bus.OVF = ovf_q;
endmodule
